// File: rtl/p1v_reset_gen.sv
// rtl/p1v_reset_gen.sv - stretched active-low reset for the p1v core from RTS, buttons and board reset
// Optional reset-cause capture enabled by defining P1V_RESET_CAUSE_EN.
module p1v_reset_gen #(
    parameter int CLK_HZ          = 160000000,
    parameter int STRETCH_MS      = 50,
    parameter int NUM_SRC         = 1,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clock_160,
    input  logic               inp_resn,
    input  logic               rts,
    input  logic [NUM_SRC-1:0] src_n,
    output logic               res_out_n,
    output logic               busy,
    output logic [NUM_SRC:0]   cause
);

    localparam logic [63:0] STRETCH_CYCLES = 64'(CLK_HZ) / 64'd1000 * 64'(STRETCH_MS);
    localparam int CNT_W = $clog2(STRETCH_CYCLES + 64'd1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_CYCLES - 64'd1);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (STRETCH_MS < 1 || NUM_SRC < 1 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
            $error("p1v_reset_gen: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HOLD,
        S_STRETCH,
        S_RUN
    } state_t;

    state_t             state_q, next_state;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] rts_sync_q;
    logic [NUM_SRC-1:0] src_sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] db_q;
    logic [DB_W-1:0]    db_cnt_q [NUM_SRC];
    logic               rts_sync;
    logic [NUM_SRC-1:0] src_sync;
    logic               req;
    logic               res_out_n_q;
    logic               busy_q;

    assign rts_sync = rts_sync_q[SYNC_STAGES-1];
    assign src_sync = src_sync_q[SYNC_STAGES-1];
    assign req      = ~rts_sync | (|(~db_q));

    // rts resets to asserted so every power-up runs through a full stretch
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            rts_sync_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) src_sync_q[s] <= '1;
        end else begin
            rts_sync_q    <= {rts_sync_q[SYNC_STAGES-2:0], rts};
            src_sync_q[0] <= src_n;
            for (int s = 1; s < SYNC_STAGES; s++) src_sync_q[s] <= src_sync_q[s-1];
        end
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            db_q <= '1;
            for (int i = 0; i < NUM_SRC; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_sync[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= src_sync[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q     <= S_HOLD;
            cnt_q       <= RELOAD;
            res_out_n_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= next_state;
            cnt_q       <= cnt_d;
            res_out_n_q <= (next_state == S_RUN);
            busy_q      <= (next_state != S_RUN);
        end
    end

    // a new request always wins over stretch expiry
    always_comb begin
        next_state = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_HOLD: begin
                cnt_d = RELOAD;
                if (!req) next_state = S_STRETCH;
            end
            S_STRETCH: begin
                if (req) begin
                    next_state = S_HOLD;
                    cnt_d      = RELOAD;
                end else if (cnt_q == '0) begin
                    next_state = S_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                if (req) begin
                    next_state = S_HOLD;
                    cnt_d      = RELOAD;
                end
            end
            default: begin
                next_state = S_HOLD;
                cnt_d      = RELOAD;
            end
        endcase
    end

    assign res_out_n = res_out_n_q;
    assign busy      = busy_q;

`ifdef P1V_RESET_CAUSE_EN
    logic [NUM_SRC:0] cause_q;
    logic [NUM_SRC:0] req_vec;
    logic             armed_q;

    assign req_vec = {~db_q, ~rts_sync};

    // armed keeps the power-on stretch from recording a cause
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            cause_q <= '0;
            armed_q <= 1'b0;
        end else begin
            if (next_state == S_RUN) armed_q <= 1'b1;
            if (state_q == S_RUN && next_state == S_HOLD) begin
                cause_q <= req_vec;
            end else if (state_q != S_RUN && armed_q) begin
                cause_q <= cause_q | req_vec;
            end
        end
    end

    assign cause = cause_q;
`else
    assign cause = '0;
`endif

endmodule

// File: tb/tb_p1v_reset_gen.sv
// tb/tb_p1v_reset_gen.sv - directed self-checking bench for p1v_reset_gen
module tb_p1v_reset_gen;

    logic       clock_160;
    logic       inp_resn;
    logic       rts;
    logic [1:0] src_n;
    logic       res_out_n;
    logic       busy;
    logic [2:0] cause;

    int checks = 0;
    int errors = 0;
    int busy_bad = 0;
    int n;
    int low_seen;

`ifdef P1V_RESET_CAUSE_EN
    localparam bit CAUSE_EN = 1'b1;
`else
    localparam bit CAUSE_EN = 1'b0;
`endif

    p1v_reset_gen #(
        .CLK_HZ          (1000000),
        .STRETCH_MS      (1),
        .NUM_SRC         (2),
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2)
    ) dut (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .rts       (rts),
        .src_n     (src_n),
        .res_out_n (res_out_n),
        .busy      (busy),
        .cause     (cause)
    );

    initial clock_160 = 1'b0;
    always #5 clock_160 = ~clock_160;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // counts clock edges until res_out_n reaches val; returns limit on timeout
    task automatic wait_res(input logic val, input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(negedge clock_160);
            edges++;
            if (busy === res_out_n) busy_bad++;
            if (res_out_n === val) break;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clock_160);
            if (busy === res_out_n) busy_bad++;
            if (res_out_n !== 1'b1) low_seen++;
        end
    endtask

    initial begin
        inp_resn = 1'b0;
        rts      = 1'b1;
        src_n    = 2'b11;

        // power-on
        repeat (5) @(negedge clock_160);
        check("rst_res_out_n", 32'(res_out_n), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_cause", 32'(cause), 0);
        inp_resn = 1'b1;
        wait_res(1'b1, 1200, n);
        check("por_release_edges", n, 1003);
        check("por_busy_after", 32'(busy), 0);
        low_seen = 0;
        idle(50);
        check("por_stays_high", low_seen, 0);
        check("por_cause", 32'(cause), 0);

        // rts pulse in RUN
        rts = 1'b0;
        wait_res(1'b0, 20, n);
        check("rts_assert_edges", n, 3);
        repeat (17) @(negedge clock_160);
        rts = 1'b1;
        wait_res(1'b1, 1200, n);
        check("rts_release_edges", n, 1003);
        check("rts_cause", 32'(cause), CAUSE_EN ? 32'd1 : 32'd0);

        // re-request mid-stretch reloads the counter
        idle(20);
        rts = 1'b0;
        repeat (10) @(negedge clock_160);
        rts = 1'b1;
        repeat (500) @(negedge clock_160);
        check("rerq_mid_low", 32'(res_out_n), 0);
        rts = 1'b0;
        repeat (10) @(negedge clock_160);
        rts = 1'b1;
        repeat (493) @(negedge clock_160);
        check("rerq_past_first_expiry", 32'(res_out_n), 0);
        wait_res(1'b1, 1200, n);
        check("rerq_release_edges", n + 493, 1003);
        check("rerq_total_low", 520 + 493 + n - 3, 1520);
        check("rerq_cause", 32'(cause), CAUSE_EN ? 32'd1 : 32'd0);

        // bounce rejection on src_n[1]
        low_seen = 0;
        for (int k = 0; k < 20; k++) begin
            src_n[1] = k[0];
            idle(3);
        end
        src_n[1] = 1'b1;
        idle(20);
        check("bounce_no_reset", low_seen, 0);
        check("bounce_cause", 32'(cause), CAUSE_EN ? 32'd1 : 32'd0);

        // button press on src_n[0]
        src_n[0] = 1'b0;
        wait_res(1'b0, 40, n);
        check("btn_assert_edges", n, 11);
        repeat (39) @(negedge clock_160);
        src_n[0] = 1'b1;
        wait_res(1'b1, 1200, n);
        check("btn_release_edges", n, 1011);
        check("btn_cause", 32'(cause), CAUSE_EN ? 32'd2 : 32'd0);

        // async reset mid-stretch at counter=400
        idle(10);
        rts = 1'b0;
        wait_res(1'b0, 20, n);
        check("ar_assert_edges", n, 3);
        repeat (7) @(negedge clock_160);
        rts = 1'b1;
        repeat (602) @(negedge clock_160);
        check("ar_mid_res", 32'(res_out_n), 0);
        check("ar_mid_busy", 32'(busy), 1);
        inp_resn = 1'b0;
        #1;
        check("ar_imm_res", 32'(res_out_n), 0);
        check("ar_imm_busy", 32'(busy), 1);
        check("ar_imm_cause", 32'(cause), 0);
        repeat (2) @(negedge clock_160);
        inp_resn = 1'b1;
        wait_res(1'b1, 1200, n);
        check("ar_release_edges", n, 1003);
        check("ar_cause_after", 32'(cause), 0);

        check("busy_complement", busy_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p1v_reset_gen.md
Name: p1v_reset_gen

Overview:
- Parametrised reset generator that replaces the ad-hoc RTS counter in the board top levels.
- Merges three kinds of input into one registered, stretched, active-low reset for the p1v core:
  - the Prop Plug RTS line,
  - NUM_SRC debounced push-button sources,
  - a board-level asynchronous reset (MMCM lock / power-on).
- Emulates the Prop Plug RC filter at any clock frequency or pulse length.
- Instantiated once per board top, between the clock generator and p1v.

Parameters:
- CLK_HZ, 160000000: clock_160 frequency in Hz.
- STRETCH_MS, 50: reset stretch after the last request releases, in ms; must be >= 1 (elaboration error otherwise).
- NUM_SRC, 1: number of active-low button sources; must be >= 1.
- DEBOUNCE_CYCLES, 16000: cycles a button input must be stable before its debounced state changes; must be >= 1.
- SYNC_STAGES, 2: synchroniser depth for rts and src_n; must be >= 2.

Ports:
- clock_160, input, 1: system clock.
- inp_resn, input, 1: asynchronous active-low reset; assertion is asynchronous; release is used as-is (caller supplies a synchronised release).
- rts, input, 1: serial RTS, asynchronous; low = reset request.
- src_n, input, NUM_SRC: button inputs, asynchronous; low = reset request.
- res_out_n, output, 1: registered stretched reset to the core; low = reset.
- busy, output, 1: high in HOLD or STRETCH.
- cause, output, NUM_SRC+1: reset cause; bit 0 = rts, bit i = src_n[i-1]. Active only with the optional feature.

Behaviour:
- One clock; reset is asynchronous and active-low.
- STRETCH_CYCLES = CLK_HZ/1000*STRETCH_MS, computed in 64-bit at elaboration.
- Counter width = $clog2(STRETCH_CYCLES+1).
- Async reset (inp_resn low):
  - outputs: res_out_n=0, busy=1, cause=0;
  - state = HOLD; stretch counter = STRETCH_CYCLES-1;
  - rts synchroniser flops = 0 (asserted), so every power-up ends with a full stretch;
  - src_n synchroniser flops and debounced states = 1 (released); debounce counters = 0.
- Synchronisers: SYNC_STAGES-flop chain per input; rts is not debounced.
- Debounce, per source:
  - counter clears whenever the synchronised input equals the debounced state; otherwise it increments;
  - when the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the debounced state takes the input and the counter clears.
- req = !rts_sync | any debounced src low.
- State machine:
  - HOLD: counter held at STRETCH_CYCLES-1. Go to STRETCH when req=0.
  - STRETCH: counter decrements by 1 each cycle. If req=1, go to HOLD and reload; a request always wins over expiry. Else if counter==0, go to RUN.
  - RUN: if req=1, go to HOLD.
- Output timing:
  - res_out_n is a flop loaded with (next_state==RUN); busy is a flop loaded with (next_state!=RUN). Neither is combinational.
  - Assertion latency: rts falling edge to res_out_n low = SYNC_STAGES+1 clocks, ±1 for async sampling.
  - Release: first STRETCH cycle is cycle 0; res_out_n rises at the clock edge ending the STRETCH cycle where counter==0, i.e. exactly STRETCH_CYCLES clocks after HOLD is left.
- Wrap-around: the counter never decrements below 0; RUN holds its value.
- Glitch handling:
  - an rts low pulse shorter than one clock may be missed;
  - a pulse lasting one full synchronised cycle restarts the full stretch.

Optional Feature:
- Macro: P1V_RESET_CAUSE_EN.
- Defined:
  - cause register loads the request vector {debounced src low bits, !rts_sync} on the RUN->HOLD transition;
  - while busy, it ORs in the request vector each cycle;
  - it holds while in RUN and clears only on inp_resn;
  - power-on stretch leaves cause=0.
- Undefined: cause tied to 0 and no cause flops are built.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=1000000, STRETCH_MS=1 (STRETCH_CYCLES=1000), NUM_SRC=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
- Power-on: inp_resn low 5 clocks then high, rts=1, src_n=2'b11 -> res_out_n=0 and busy=1 throughout; res_out_n rises 1000 clocks after leaving HOLD (3 clocks of sync), then stays 1.
- RTS pulse in RUN: rts low 20 clocks -> res_out_n low within 3 clocks; high 1000 clocks after HOLD exit; with cause enabled, cause=3'b001.
- Re-request mid-stretch: rts low 10 clocks, high 500 clocks, low 10 clocks -> counter reloads; res_out_n rises 1000 clocks after the second HOLD exit, total low time > 1500 clocks.
- Bounce rejection: src_n[1] toggles every 3 clocks for 60 clocks, then returns to 1 -> res_out_n stays 1, cause unchanged.
- Button press: src_n[0] held low 50 clocks -> res_out_n falls 8+2+1 clocks after the edge; release debounced after 8 clocks, then stretched 1000; cause=3'b010.
- Async reset mid-stretch: inp_resn pulsed low in STRETCH at counter=400 -> res_out_n=0 and busy=1 immediately; cause=0; a full 1000-clock stretch follows.
